// File: rtl/sprite_pkg.sv
// Shared types and default widths for the sprite draw scheduler.
// The FSM state enum lives here so the bench and RTL agree on names.
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int X_W_DEF  = 8;
   localparam int Y_W_DEF  = 7;
   localparam int SZ_W_DEF = 5;
   localparam int C_W_DEF  = 3;

   localparam logic [2:0] BG_COLOR_DEF = 3'b000;

endpackage

// File: rtl/sprite_draw_scheduler_slot_select.sv
// Combinational extractor of one slot from a packed descriptor bank.
// The colour can be overridden for the erase pass.
module slot_select #(
   parameter int NUM_OBJ = 5,
   parameter int X_W     = sprite_pkg::X_W_DEF,
   parameter int Y_W     = sprite_pkg::Y_W_DEF,
   parameter int SZ_W    = sprite_pkg::SZ_W_DEF,
   parameter int C_W     = sprite_pkg::C_W_DEF,
   parameter int IW      = $clog2(NUM_OBJ)
) (
   input  logic [NUM_OBJ*X_W-1:0]  bank_x,
   input  logic [NUM_OBJ*Y_W-1:0]  bank_y,
   input  logic [NUM_OBJ*SZ_W-1:0] bank_w,
   input  logic [NUM_OBJ*SZ_W-1:0] bank_h,
   input  logic [NUM_OBJ*C_W-1:0]  bank_c,
   input  logic [NUM_OBJ-1:0]      bank_en,
   input  logic [IW-1:0]           idx,
   input  logic                    force_c,
   input  logic [C_W-1:0]          force_val,
   output logic [X_W-1:0]          x,
   output logic [Y_W-1:0]          y,
   output logic [SZ_W-1:0]         w,
   output logic [SZ_W-1:0]         h,
   output logic [C_W-1:0]          c,
   output logic                    en
);

   always_comb begin
      x  = bank_x[int'(idx)*X_W +: X_W];
      y  = bank_y[int'(idx)*Y_W +: Y_W];
      w  = bank_w[int'(idx)*SZ_W +: SZ_W];
      h  = bank_h[int'(idx)*SZ_W +: SZ_W];
      c  = force_c ? force_val : bank_c[int'(idx)*C_W +: C_W];
      en = bank_en[idx];
   end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Frame-level draw sequencer: snapshots object descriptors, optionally
// erases the previous frame, then issues one rectangle per visible slot.
module sprite_draw_scheduler #(
   parameter int NUM_OBJ = 5,
   parameter int X_W     = sprite_pkg::X_W_DEF,
   parameter int Y_W     = sprite_pkg::Y_W_DEF,
   parameter int SZ_W    = sprite_pkg::SZ_W_DEF,
   parameter int C_W     = sprite_pkg::C_W_DEF,
   parameter logic [C_W-1:0] BG_COLOR = C_W'(sprite_pkg::BG_COLOR_DEF)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_start,
   input  logic                    erase_en,
   input  logic [NUM_OBJ*X_W-1:0]  obj_x,
   input  logic [NUM_OBJ*Y_W-1:0]  obj_y,
   input  logic [NUM_OBJ*SZ_W-1:0] obj_w,
   input  logic [NUM_OBJ*SZ_W-1:0] obj_h,
   input  logic [NUM_OBJ*C_W-1:0]  obj_c,
   input  logic [NUM_OBJ-1:0]      obj_en,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic [X_W-1:0]          req_x,
   output logic [Y_W-1:0]          req_y,
   output logic [SZ_W-1:0]         req_w,
   output logic [SZ_W-1:0]         req_h,
   output logic [C_W-1:0]          req_c,
   output logic                    busy,
   output logic                    frame_done
);
   import sprite_pkg::*;

   localparam int IW = $clog2(NUM_OBJ);
   localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);

   state_e state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;

   logic [NUM_OBJ*X_W-1:0]  cur_x_q, cur_x_d, prev_x_q, prev_x_d;
   logic [NUM_OBJ*Y_W-1:0]  cur_y_q, cur_y_d, prev_y_q, prev_y_d;
   logic [NUM_OBJ*SZ_W-1:0] cur_w_q, cur_w_d, prev_w_q, prev_w_d;
   logic [NUM_OBJ*SZ_W-1:0] cur_h_q, cur_h_d, prev_h_q, prev_h_d;
   logic [NUM_OBJ*C_W-1:0]  cur_c_q, cur_c_d, prev_c_q, prev_c_d;
   logic [NUM_OBJ-1:0]      cur_en_q, cur_en_d, prev_en_q, prev_en_d;

   logic [X_W-1:0]  cx, px;
   logic [Y_W-1:0]  cy, py;
   logic [SZ_W-1:0] cw, pw, ch, ph;
   logic [C_W-1:0]  cc, pc;
   logic            cen, pen;
   logic            capture, slot_en, advance;

   slot_select #(
      .NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W),
      .SZ_W(SZ_W), .C_W(C_W), .IW(IW)
   ) u_cur (
      .bank_x(cur_x_q), .bank_y(cur_y_q), .bank_w(cur_w_q),
      .bank_h(cur_h_q), .bank_c(cur_c_q), .bank_en(cur_en_q),
      .idx(idx_q), .force_c(1'b0), .force_val('0),
      .x(cx), .y(cy), .w(cw), .h(ch), .c(cc), .en(cen)
   );

   slot_select #(
      .NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W),
      .SZ_W(SZ_W), .C_W(C_W), .IW(IW)
   ) u_prev (
      .bank_x(prev_x_q), .bank_y(prev_y_q), .bank_w(prev_w_q),
      .bank_h(prev_h_q), .bank_c(prev_c_q), .bank_en(prev_en_q),
      .idx(idx_q), .force_c(1'b1), .force_val(BG_COLOR),
      .x(px), .y(py), .w(pw), .h(ph), .c(pc), .en(pen)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cur_x_q   <= '0;
         cur_y_q   <= '0;
         cur_w_q   <= '0;
         cur_h_q   <= '0;
         cur_c_q   <= '0;
         cur_en_q  <= '0;
         prev_x_q  <= '0;
         prev_y_q  <= '0;
         prev_w_q  <= '0;
         prev_h_q  <= '0;
         prev_c_q  <= '0;
         prev_en_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
         cur_w_q   <= cur_w_d;
         cur_h_q   <= cur_h_d;
         cur_c_q   <= cur_c_d;
         cur_en_q  <= cur_en_d;
         prev_x_q  <= prev_x_d;
         prev_y_q  <= prev_y_d;
         prev_w_q  <= prev_w_d;
         prev_h_q  <= prev_h_d;
         prev_c_q  <= prev_c_d;
         prev_en_q <= prev_en_d;
      end
   end

   // A hidden slot still costs one cycle; a visible one waits for ready.
   always_comb begin
      capture = (state_q == IDLE) && frame_start;
      slot_en = (state_q == ERASE) ? pen : cen;
      advance = !slot_en || req_ready;
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = erase_en ? ERASE : DRAW;
               idx_d   = '0;
            end
         end
         ERASE, DRAW: begin
            if (advance) begin
               if (idx_q == LAST) begin
                  state_d = (state_q == ERASE) ? DRAW : DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      cur_x_d   = capture ? obj_x  : cur_x_q;
      cur_y_d   = capture ? obj_y  : cur_y_q;
      cur_w_d   = capture ? obj_w  : cur_w_q;
      cur_h_d   = capture ? obj_h  : cur_h_q;
      cur_c_d   = capture ? obj_c  : cur_c_q;
      cur_en_d  = capture ? obj_en : cur_en_q;
      prev_x_d  = capture ? cur_x_q  : prev_x_q;
      prev_y_d  = capture ? cur_y_q  : prev_y_q;
      prev_w_d  = capture ? cur_w_q  : prev_w_q;
      prev_h_d  = capture ? cur_h_q  : prev_h_q;
      prev_c_d  = capture ? cur_c_q  : prev_c_q;
      prev_en_d = capture ? cur_en_q : prev_en_q;
   end

   always_comb begin
      req_valid  = 1'b0;
      req_x      = '0;
      req_y      = '0;
      req_w      = '0;
      req_h      = '0;
      req_c      = '0;
      busy       = (state_q != IDLE);
      frame_done = (state_q == DONE);
      case (state_q)
         ERASE: begin
            req_valid = pen;
            req_x     = px;
            req_y     = py;
            req_w     = pw;
            req_h     = ph;
            req_c     = pc;
         end
         DRAW: begin
            req_valid = cen;
            req_x     = cx;
            req_y     = cy;
            req_w     = cw;
            req_h     = ch;
            req_c     = cc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Randomised bench for sprite_draw_scheduler with a schedule-queue model.
module tb_sprite_draw_scheduler;

   localparam int N  = 5;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int SW = 5;
   localparam int CW = 3;
   localparam logic [2:0] BG = 3'b000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic frame_start = 1'b0;
   logic erase_en = 1'b0;
   logic req_ready = 1'b1;
   logic [N*XW-1:0] obj_x = '0;
   logic [N*YW-1:0] obj_y = '0;
   logic [N*SW-1:0] obj_w = '0;
   logic [N*SW-1:0] obj_h = '0;
   logic [N*CW-1:0] obj_c = '0;
   logic [N-1:0]    obj_en = '0;
   logic            req_valid, busy, frame_done;
   logic [XW-1:0]   req_x;
   logic [YW-1:0]   req_y;
   logic [SW-1:0]   req_w, req_h;
   logic [CW-1:0]   req_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sprite_draw_scheduler #(
      .NUM_OBJ(N), .X_W(XW), .Y_W(YW), .SZ_W(SW), .C_W(CW), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .reset(rst_n), .frame_start(frame_start),
      .erase_en(erase_en), .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w),
      .obj_h(obj_h), .obj_c(obj_c), .obj_en(obj_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
      .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_c(req_c),
      .busy(busy), .frame_done(frame_done)
   );

   typedef struct {bit v; int x; int y; int w; int h; int c;} ent_t;
   typedef struct {int x; int y; int c;} xfer_t;

   // Model: a frame is a flat list of slot entries, then one done cycle.
   ent_t  sched[$];
   bit    m_done = 0;
   xfer_t log_q[$];
   int cx[N], cy[N], cw[N], ch[N], cc[N], cen[N];
   int px[N], py[N], pw[N], ph[N], pc[N], pen[N];

   initial begin : model
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            sched.delete();
            m_done = 0;
            for (int i = 0; i < N; i++) begin
               cx[i] = 0; cy[i] = 0; cw[i] = 0; ch[i] = 0; cc[i] = 0; cen[i] = 0;
               px[i] = 0; py[i] = 0; pw[i] = 0; ph[i] = 0; pc[i] = 0; pen[i] = 0;
            end
         end else if (m_done) begin
            m_done = 0;
         end else if (sched.size() != 0) begin
            if (!sched[0].v || req_ready) begin
               void'(sched.pop_front());
               if (sched.size() == 0) m_done = 1;
            end
         end else if (frame_start) begin
            for (int i = 0; i < N; i++) begin
               px[i] = cx[i]; py[i] = cy[i]; pw[i] = cw[i];
               ph[i] = ch[i]; pc[i] = cc[i]; pen[i] = cen[i];
               cx[i] = int'(obj_x[i*XW +: XW]);
               cy[i] = int'(obj_y[i*YW +: YW]);
               cw[i] = int'(obj_w[i*SW +: SW]);
               ch[i] = int'(obj_h[i*SW +: SW]);
               cc[i] = int'(obj_c[i*CW +: CW]);
               cen[i] = int'(obj_en[i]);
            end
            if (erase_en)
               for (int i = 0; i < N; i++)
                  sched.push_back('{pen[i] != 0, px[i], py[i], pw[i], ph[i], int'(BG)});
            for (int i = 0; i < N; i++)
               sched.push_back('{cen[i] != 0, cx[i], cy[i], cw[i], ch[i], cc[i]});
         end
      end
   end

   initial begin : compare
      bit ev, eb, ed, chk_f;
      int ex, ey, ew, eh, ec;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b0 || $time > 2) begin
            if (sched.size() != 0) begin
               ev = sched[0].v; eb = 1; ed = 0; chk_f = ev;
               ex = sched[0].x; ey = sched[0].y; ew = sched[0].w;
               eh = sched[0].h; ec = sched[0].c;
            end else begin
               ev = 0; eb = m_done; ed = m_done; chk_f = !m_done;
               ex = 0; ey = 0; ew = 0; eh = 0; ec = 0;
            end
            checks++;
            if (req_valid !== ev || busy !== eb || frame_done !== ed ||
                (chk_f && (int'(req_x) != ex || int'(req_y) != ey ||
                           int'(req_w) != ew || int'(req_h) != eh ||
                           int'(req_c) != ec))) begin
               errors++;
               $display("FAIL cycle t=%0t v/b/d %0b%0b%0b want %0b%0b%0b xywhc %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d",
                        $time, req_valid, busy, frame_done, ev, eb, ed,
                        req_x, req_y, req_w, req_h, req_c, ex, ey, ew, eh, ec);
            end
            if (req_valid && req_ready)
               log_q.push_back('{int'(req_x), int'(req_y), int'(req_c)});
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int log_x(input int i);
      return (i < log_q.size()) ? log_q[i].x : -1;
   endfunction

   function automatic int log_c(input int i);
      return (i < log_q.size()) ? log_q[i].c : -1;
   endfunction

   task automatic set_slot(input int i, input int x, input int y,
                           input int w, input int h, input int c);
      obj_x[i*XW +: XW] = XW'(x);
      obj_y[i*YW +: YW] = YW'(y);
      obj_w[i*SW +: SW] = SW'(w);
      obj_h[i*SW +: SW] = SW'(h);
      obj_c[i*CW +: CW] = CW'(c);
   endtask

   // mode 0: ready held; 1: random ready + input churn; 2: 3-cycle stall
   // on slot 1; 3: frame_start and obj_x poked mid-frame.
   task automatic run_frame(input bit e, input int mode, output int len);
      @(posedge clk);
      #1 frame_start = 1'b1;
      erase_en = e;
      @(posedge clk);
      #1 frame_start = 1'b0;
      erase_en = 1'($urandom_range(0, 1));
      len = 0;
      while (1) begin
         len++;
         @(negedge clk);
         if (frame_done) break;
         if (len >= 300) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout len %0d limit 300", len);
            break;
         end
         @(posedge clk);
         #1;
         case (mode)
            1: begin
               req_ready = ($urandom_range(0, 3) != 0);
               obj_x = (N*XW)'({$urandom(), $urandom()});
               obj_en = N'($urandom());
            end
            2: begin
               if (len == 1) req_ready = 1'b0;
               if (len == 4) req_ready = 1'b1;
            end
            3: begin
               if (len == 2) begin frame_start = 1'b1; obj_x = '1; end
               if (len == 3) frame_start = 1'b0;
            end
            default: ;
         endcase
      end
      req_ready = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin : main
      int len;
      int exp_n;
      logic [N-1:0] last_en;
      bit e;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_valid", int'(req_valid), 0);

      for (int i = 0; i < N; i++) set_slot(i, 10*i, i, i+1, i+2, i);
      obj_en = '1;
      log_q.delete();
      run_frame(0, 0, len);
      chk("f1_len", len, 6);
      chk("f1_count", log_q.size(), 5);
      for (int i = 0; i < N; i++) chk("f1_x", log_x(i), 10*i);

      for (int i = 0; i < N; i++) set_slot(i, 100+5*i, 20+i, 3, 4, 7-i);
      log_q.delete();
      run_frame(1, 0, len);
      chk("f2_len", len, 11);
      chk("f2_count", log_q.size(), 10);
      for (int i = 0; i < N; i++) begin
         chk("f2_erase_x", log_x(i), 10*i);
         chk("f2_erase_c", log_c(i), 0);
         chk("f2_draw_x", log_x(5+i), 100+5*i);
         chk("f2_draw_c", log_c(5+i), 7-i);
      end

      obj_en = 5'b10101;
      log_q.delete();
      run_frame(0, 0, len);
      chk("f3_len", len, 6);
      chk("f3_count", log_q.size(), 3);
      chk("f3_x0", log_x(0), 100);
      chk("f3_x1", log_x(1), 110);
      chk("f3_x2", log_x(2), 120);

      obj_en = '1;
      log_q.delete();
      run_frame(0, 2, len);
      chk("stall_len", len, 9);
      chk("stall_count", log_q.size(), 5);
      for (int i = 0; i < N; i++) chk("stall_x", log_x(i), 100+5*i);

      log_q.delete();
      run_frame(0, 3, len);
      chk("poke_len", len, 6);
      chk("poke_count", log_q.size(), 5);
      for (int i = 0; i < N; i++) chk("poke_x", log_x(i), 100+5*i);
      for (int i = 0; i < N; i++) set_slot(i, 100+5*i, 20+i, 3, 4, 7-i);

      @(posedge clk);
      #1 frame_start = 1'b1;
      erase_en = 1'b0;
      @(posedge clk);
      #1 frame_start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_valid", int'(req_valid), 0);
      chk("abort_busy", int'(busy), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      log_q.delete();
      run_frame(1, 0, len);
      chk("post_reset_len", len, 11);
      chk("post_reset_count", log_q.size(), 5);
      chk("post_reset_c0", log_c(0), 7);
      last_en = obj_en;

      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < N; i++)
            set_slot(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 7)));
         obj_en = N'($urandom());
         e = 1'($urandom_range(0, 1));
         exp_n = $countones(obj_en) + (e ? $countones(last_en) : 0);
         last_en = obj_en;
         log_q.delete();
         run_frame(e, 1, len);
         chk("rand_count", log_q.size(), exp_n);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Frame-level draw sequencer between the game-object logic and the rectangle drawer. On each frame request it snapshots NUM_OBJ object descriptors (position, size, colour, visibility). It then issues one rectangle request per visible object over a valid/ready handshake. An optional erase pass first repaints the previous frame's rectangles in the background colour. It replaces fixed five-object, externally-indexed selection with an autonomous, parametrised scheduler.

## Interface
Parameters:
- NUM_OBJ, 5, number of object slots (≥2); slot 0 is the player.
- X_W, 8, x-coordinate width.
- Y_W, 7, y-coordinate width.
- SZ_W, 5, width/height field width.
- C_W, 3, colour width.
- BG_COLOR, 3'b000, colour used in the erase pass.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle frame request; honoured only in IDLE.
- erase_en  in  1  run the erase pass this frame; sampled with frame_start.
- obj_x  in  NUM_OBJ*X_W  packed x; slot i occupies bits [i*X_W +: X_W].
- obj_y  in  NUM_OBJ*Y_W  packed y, same packing.
- obj_w  in  NUM_OBJ*SZ_W  packed widths.
- obj_h  in  NUM_OBJ*SZ_W  packed heights.
- obj_c  in  NUM_OBJ*C_W  packed colours.
- obj_en  in  NUM_OBJ  per-slot visible flag.
- req_valid  out  1  rectangle request valid.
- req_ready  in  1  drawer accepts the request.
- req_x  out  X_W  rectangle start x.
- req_y  out  Y_W  rectangle start y.
- req_w  out  SZ_W  rectangle width.
- req_h  out  SZ_W  rectangle height.
- req_c  out  C_W  rectangle colour.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.

## Operation
- Storage: a cur bank and a prev bank, each holding NUM_OBJ descriptors plus an en mask.
  - On reset: both banks are cleared, including both en masks.
- FSM states: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - frame_start=1 copies cur to prev, captures all inputs into cur, and latches erase_en.
  - It sets idx=0 and goes to ERASE if erase_en=1, else DRAW.
- ERASE: request = prev[idx] with colour forced to BG_COLOR.
- DRAW: request = cur[idx] with its own colour.
- Slot stepping in ERASE and DRAW:
  - If the bank's en[idx]=0, the slot is skipped in one cycle with req_valid=0.
  - If en[idx]=1, req_valid=1 is held until req_ready=1, then idx advances.
  - After slot NUM_OBJ-1: ERASE goes to DRAW with idx reset to 0; DRAW goes to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- frame_start outside IDLE is ignored and not queued; input changes during a frame are not observed.
- The first frame after reset erases nothing, because prev en is all zero.
- Widths: idx is $clog2(NUM_OBJ) bits. No coordinate arithmetic is performed; fields pass through unmodified.

## Timing
- Reset values: req_valid=0, busy=0, frame_done=0; req_x/y/w/h/c=0; state=IDLE, idx=0.
- Reset is asynchronous. Asserting it mid-frame aborts immediately: no further req_valid and no frame_done.
- req_* and req_valid are decoded combinationally from registered state/idx/banks; no input-to-output combinational path.
- With frame_start sampled at edge T, the first possible req_valid is in cycle T+1.
- Handshake:
  - A transfer occurs on any edge with req_valid && req_ready.
  - While req_valid=1 && req_ready=0, all req_* stay stable.
  - req_valid does not drop without a transfer, except on reset.
- Each slot costs exactly one cycle with ready held high, plus stall cycles.
- Frame length: (erase_en ? 2 : 1)*NUM_OBJ + 1 cycles (DONE included), plus stalls.
- A new frame_start is accepted in the cycle after frame_done.

## Structure
- Shared package sprite_pkg holds:
  - the state enum (IDLE, ERASE, DRAW, DONE);
  - default widths X_W/Y_W/SZ_W/C_W;
  - BG_COLOR default.
- Sub-module slot_select: parametrised combinational extractor of slot idx from the packed banks. It is instantiated twice (cur, prev), and the FSM muxes between them.

## Test plan
- Reset, then frame_start with erase_en=0, all en=1, ready=1, slot i at x=10*i, y=i, c=i → 5 consecutive transfers x=0,10,20,30,40; frame_done 6 cycles after capture; busy high throughout.
- Second frame with erase_en=1 and new positions → first 5 transfers replay the previous positions with c=000, then 5 transfers at the new positions; frame_done after 11 cycles.
- obj_en=5'b10101 → only slots 0,2,4 are requested; frame still takes 6 cycles; req_valid low in skipped cycles.
- ready low for 3 cycles on slot 1 → req_valid held and req_* unchanged during the stall; total frame 9 cycles; no duplicate or dropped slot.
- frame_start pulsed again mid-frame, plus obj_x changed mid-frame → ignored; outputs reflect the captured snapshot only.
- Reset asserted during DRAW at slot 2 → req_valid=0 and busy=0 immediately. The next frame with erase_en=1 issues no erase requests.
